// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver: serial line, parity select, and the
// character/status outputs held under the rx_valid / rx_ack handshake.
interface uart_rx_if;
    logic       rxd;
    logic       p_s;
    logic       rx_ack;
    logic [6:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output rxd, p_s, rx_ack,
        input  rx_data, rx_valid, parity_err, frame_err, overrun, busy
    );

    modport slave (
        input  rxd, p_s, rx_ack,
        output rx_data, rx_valid, parity_err, frame_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx_datapath.sv
// UART receiver for 7-bit characters with one parity bit and one stop bit,
// sampling at mid-bit and presenting each character under a valid/ack handshake.
module uart_rx_datapath #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave bus
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic             shift_en;
    logic             par_en;
    logic             done;

    logic             rxd_p0;
    logic             rxd_p1;
    logic             rxd_s;

    logic [6:0]       shift_reg;
    logic             par_err_q;

    logic [6:0]       rx_data_q;
    logic             rx_valid_q;
    logic             parity_err_q;
    logic             frame_err_q;
    logic             overrun_q;

    // Even parity expects p_bit == ^data; odd expects its complement.
    function automatic logic parity_check(input logic p_bit, input logic [6:0] data,
                                          input logic sel_odd);
        return p_bit ^ (^data) ^ sel_odd;
    endfunction

    // ---- stage p0/p1: two-flop synchronizer, idles high ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
        end else begin
            rxd_p0 <= bus.rxd;
            rxd_p1 <= rxd_p0;
        end
    end

    assign rxd_s = rxd_p1;

    // ---- frame FSM: state and counters ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_cnt <= bit_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_cnt_n = bit_cnt;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                if (!rxd_s) state_n = START;
            end
            START: begin
                if (clk_cnt == CNT_MID) begin
                    // A line back high at mid-start is a glitch, not a frame.
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    state_n   = rxd_s ? IDLE : DATA;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    shift_en  = 1'b1;
                    clk_cnt_n = '0;
                    if (bit_cnt == 3'd6) begin
                        bit_cnt_n = '0;
                        state_n   = PARITY;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (clk_cnt == CNT_LAST) begin
                    par_en    = 1'b1;
                    clk_cnt_n = '0;
                    state_n   = STOP;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                // Leaving at mid-stop lets the next start bit follow immediately.
                if (clk_cnt == CNT_LAST) begin
                    done      = 1'b1;
                    clk_cnt_n = '0;
                    state_n   = IDLE;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            default: begin
                state_n   = IDLE;
                clk_cnt_n = '0;
                bit_cnt_n = '0;
            end
        endcase
    end

    // ---- stage p2: character assembly and parity evaluation ----
    always_ff @(posedge clk) begin
        if (shift_en) shift_reg[bit_cnt] <= rxd_s;
        if (par_en)   par_err_q <= parity_check(rxd_s, shift_reg, bus.p_s);
    end

    // ---- output registers and host handshake ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (done) begin
            rx_data_q    <= shift_reg;
            parity_err_q <= par_err_q;
            frame_err_q  <= ~rxd_s;
            overrun_q    <= overrun_q | (rx_valid_q & ~bus.rx_ack);
            rx_valid_q   <= 1'b1;
        end else if (bus.rx_ack) begin
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_datapath.sv
// Directed bench for uart_rx_datapath: a table of single frames followed by
// hand-written sequences for glitches, back-to-back frames, break and reset.
module tb_uart_rx_datapath;

    localparam int CPB = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    uart_rx_if bus();

    uart_rx_datapath #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] ch;
        logic       pbit;
        logic       stopb;
        logic       ps;
        logic [6:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] make_frame(input logic [6:0] ch, input logic pb,
                                              input logic sb);
        return {sb, pb, ch, 1'b0};
    endfunction

    // Drives a 10-bit frame starting on a negedge; with ack_stop, rx_ack is high
    // exactly across the edge on which the stop bit is sampled (edge 155 of the frame).
    task automatic send_frame(input logic [9:0] f, input bit ack_stop);
        for (int i = 0; i < 10; i++) begin
            bus.rxd = f[i];
            for (int j = 0; j < CPB; j++) begin
                bus.rx_ack = ack_stop && (i == 9) && (j == 10);
                @(negedge clk);
            end
        end
        bus.rx_ack = 1'b0;
        bus.rxd    = 1'b1;
    endtask

    task automatic ack_pulse();
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
    endtask

    initial begin
        int busy_seen;
        int valid_seen;
        checks = 0;
        errors = 0;

        vecs[0] = '{7'h41, 1'b0, 1'b1, 1'b0, 7'h41, 1'b0, 1'b0};
        vecs[1] = '{7'h41, 1'b1, 1'b1, 1'b1, 7'h41, 1'b0, 1'b0};
        vecs[2] = '{7'h41, 1'b0, 1'b1, 1'b1, 7'h41, 1'b1, 1'b0};
        vecs[3] = '{7'h55, 1'b0, 1'b0, 1'b0, 7'h55, 1'b0, 1'b1};
        vecs[4] = '{7'h7F, 1'b1, 1'b1, 1'b0, 7'h7F, 1'b0, 1'b0};
        vecs[5] = '{7'h00, 1'b1, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0};
        vecs[6] = '{7'h2A, 1'b0, 1'b1, 1'b1, 7'h2A, 1'b0, 1'b0};

        bus.rxd    = 1'b1;
        bus.p_s    = 1'b0;
        bus.rx_ack = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("reset_rx_data",    32'(bus.rx_data),    32'h0);
        chk("reset_rx_valid",   32'(bus.rx_valid),   32'h0);
        chk("reset_parity_err", 32'(bus.parity_err), 32'h0);
        chk("reset_frame_err",  32'(bus.frame_err),  32'h0);
        chk("reset_overrun",    32'(bus.overrun),    32'h0);
        chk("reset_busy",       32'(bus.busy),       32'h0);
        repeat (4) @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            bus.p_s = vecs[k].ps;
            send_frame(make_frame(vecs[k].ch, vecs[k].pbit, vecs[k].stopb), 1'b0);
            chk($sformatf("vec%0d_valid", k),   32'(bus.rx_valid),   32'h1);
            chk($sformatf("vec%0d_data", k),    32'(bus.rx_data),    32'(vecs[k].exp_data));
            chk($sformatf("vec%0d_perr", k),    32'(bus.parity_err), 32'(vecs[k].exp_perr));
            chk($sformatf("vec%0d_ferr", k),    32'(bus.frame_err),  32'(vecs[k].exp_ferr));
            chk($sformatf("vec%0d_overrun", k), 32'(bus.overrun),    32'h0);
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d_hold", k),    32'(bus.rx_valid),   32'h1);
            ack_pulse();
            chk($sformatf("vec%0d_acked", k),   32'(bus.rx_valid),   32'h0);
            chk($sformatf("vec%0d_data_kept", k), 32'(bus.rx_data),  32'(vecs[k].exp_data));
            repeat (24) @(negedge clk);
        end

        // Short low glitch: START is entered but abandoned at mid-bit.
        bus.p_s    = 1'b0;
        busy_seen  = 0;
        valid_seen = 0;
        bus.rxd = 1'b0;
        repeat (3) @(negedge clk);
        bus.rxd = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.busy)     busy_seen = 1;
            if (bus.rx_valid) valid_seen = 1;
        end
        chk("glitch_busy_pulsed", 32'(busy_seen),  32'h1);
        chk("glitch_no_valid",    32'(valid_seen), 32'h0);
        chk("glitch_busy_end",    32'(bus.busy),   32'h0);

        // Break: line held low yields zero characters with frame errors.
        bus.rxd = 1'b0;
        repeat (170) @(negedge clk);
        chk("break_valid", 32'(bus.rx_valid),   32'h1);
        chk("break_data",  32'(bus.rx_data),    32'h0);
        chk("break_ferr",  32'(bus.frame_err),  32'h1);
        chk("break_perr",  32'(bus.parity_err), 32'h0);
        bus.rxd = 1'b1;
        repeat (200) @(negedge clk);
        ack_pulse();
        chk("break_cleared_valid",   32'(bus.rx_valid), 32'h0);
        chk("break_cleared_overrun", 32'(bus.overrun),  32'h0);
        repeat (4) @(negedge clk);

        // Back-to-back without ack sets overrun; a lone ack clears it.
        send_frame(make_frame(7'h12, 1'b0, 1'b1), 1'b0);
        send_frame(make_frame(7'h34, 1'b1, 1'b1), 1'b0);
        chk("b2b_data",    32'(bus.rx_data),  32'h34);
        chk("b2b_valid",   32'(bus.rx_valid), 32'h1);
        chk("b2b_overrun", 32'(bus.overrun),  32'h1);
        chk("b2b_perr",    32'(bus.parity_err), 32'h0);
        ack_pulse();
        chk("b2b_ack_overrun", 32'(bus.overrun),  32'h0);
        chk("b2b_ack_valid",   32'(bus.rx_valid), 32'h0);

        // Ack between frames: no overrun.
        send_frame(make_frame(7'h12, 1'b0, 1'b1), 1'b0);
        ack_pulse();
        send_frame(make_frame(7'h34, 1'b1, 1'b1), 1'b0);
        chk("b2b_acked_data",    32'(bus.rx_data), 32'h34);
        chk("b2b_acked_overrun", 32'(bus.overrun), 32'h0);

        // Ack on the completion edge: new data loads, valid stays, no overrun.
        send_frame(make_frame(7'h56, 1'b0, 1'b1), 1'b1);
        chk("simul_data",    32'(bus.rx_data),  32'h56);
        chk("simul_valid",   32'(bus.rx_valid), 32'h1);
        chk("simul_overrun", 32'(bus.overrun),  32'h0);

        // Reset during data bit 3 of a frame, with a character still pending.
        bus.rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 1; i < 5; i++) begin
            bus.rxd = i[0];
            repeat ((i == 4) ? CPB / 2 : CPB) @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        bus.rxd = 1'b1;
        chk("midrst_data",    32'(bus.rx_data),    32'h0);
        chk("midrst_valid",   32'(bus.rx_valid),   32'h0);
        chk("midrst_perr",    32'(bus.parity_err), 32'h0);
        chk("midrst_ferr",    32'(bus.frame_err),  32'h0);
        chk("midrst_overrun", 32'(bus.overrun),    32'h0);
        chk("midrst_busy",    32'(bus.busy),       32'h0);
        repeat (200) @(negedge clk);
        chk("midrst_no_output", 32'(bus.rx_valid), 32'h0);
        send_frame(make_frame(7'h7F, 1'b1, 1'b1), 1'b0);
        chk("post_rst_valid",   32'(bus.rx_valid),   32'h1);
        chk("post_rst_data",    32'(bus.rx_data),    32'h7F);
        chk("post_rst_perr",    32'(bus.parity_err), 32'h0);
        chk("post_rst_ferr",    32'(bus.frame_err),  32'h0);
        chk("post_rst_overrun", 32'(bus.overrun),    32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
